pipe_add_sub: RTL and testbench

//  Two-stage pipelined WIDTH-bit adder/subtractor in the execute path. It feeds the

---
 rtl/pipe_add_sub.sv | 132 +++++++++++++
 tb/tb_pipe_add_sub.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_sub.sv
// Two-stage pipelined add/sub with the carry chain split at WIDTH/2.
// Ports: clk/rst/flush, in_* handshake + operands, out_* handshake + result/flags.
module pipe_add_sub #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sb,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             sb_o,
  output logic             a_sign,
  output logic             b_sign,
  output logic             s_sign,
  output logic [TAG_W-1:0] tag_out
);

  localparam int H = WIDTH / 2;

  logic             r_s1_valid;
  logic [H-1:0]     r_s1_lo;
  logic             r_s1_cmid;
  logic [H-1:0]     r_s1_ahi;
  logic [H-1:0]     r_s1_bxhi;
  logic             r_s1_sb;
  logic             r_s1_as;
  logic             r_s1_bs;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_sum;
  logic             r_s2_c;
  logic             r_s2_sb;
  logic             r_s2_as;
  logic             r_s2_bs;
  logic             r_s2_ss;
  logic [TAG_W-1:0] r_s2_tag;

  logic [WIDTH-1:0] w_bx;
  logic [H:0]       w_lo;
  logic [H:0]       w_hi;
  logic             w_adv2;
  logic             w_acc;

  // Subtract as a + ~b + 1; the +1 rides in as carry-in of the low half.
  assign w_bx = sb ? ~b : b;
  assign w_lo = {1'b0, a[H-1:0]} + {1'b0, w_bx[H-1:0]}
              + {{H{1'b0}}, sb};
  assign w_hi = {1'b0, r_s1_ahi} + {1'b0, r_s1_bxhi}
              + {{H{1'b0}}, r_s1_cmid};

  assign w_adv2   = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready = !rst && !flush && (!r_s1_valid || w_adv2);
  assign w_acc    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_acc)
        r_s1_valid <= 1'b1;
      else if (w_adv2)
        r_s1_valid <= 1'b0;
      if (w_adv2)
        r_s2_valid <= 1'b1;
      else if (out_ready)
        r_s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_lo   <= '0;
      r_s1_cmid <= 1'b0;
      r_s1_ahi  <= '0;
      r_s1_bxhi <= '0;
      r_s1_sb   <= 1'b0;
      r_s1_as   <= 1'b0;
      r_s1_bs   <= 1'b0;
      r_s1_tag  <= '0;
    end else if (w_acc) begin
      r_s1_lo   <= w_lo[H-1:0];
      r_s1_cmid <= w_lo[H];
      r_s1_ahi  <= a[WIDTH-1:H];
      r_s1_bxhi <= w_bx[WIDTH-1:H];
      r_s1_sb   <= sb;
      r_s1_as   <= a[WIDTH-1];
      r_s1_bs   <= b[WIDTH-1];
      r_s1_tag  <= tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_sum <= '0;
      r_s2_c   <= 1'b0;
      r_s2_sb  <= 1'b0;
      r_s2_as  <= 1'b0;
      r_s2_bs  <= 1'b0;
      r_s2_ss  <= 1'b0;
      r_s2_tag <= '0;
    end else if (w_adv2 && !flush) begin
      r_s2_sum <= {w_hi[H-1:0], r_s1_lo};
      r_s2_c   <= w_hi[H];
      r_s2_sb  <= r_s1_sb;
      r_s2_as  <= r_s1_as;
      r_s2_bs  <= r_s1_bs;
      r_s2_ss  <= w_hi[H-1];
      r_s2_tag <= r_s1_tag;
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_s2_sum;
  assign c_out     = r_s2_c;
  assign sb_o      = r_s2_sb;
  assign a_sign    = r_s2_as;
  assign b_sign    = r_s2_bs;
  assign s_sign    = r_s2_ss;
  assign tag_out   = r_s2_tag;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: directed cases,
// backpressure, flush, reset and a randomized scoreboard run.
module tb_pipe_add_sub;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        sb;
    logic        as;
    logic        bs;
    logic        ss;
    logic [3:0]  tag;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sb = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        c_out, sb_o, a_sign, b_sign, s_sign;
  logic [3:0]  tag_out;

  int total = 0;
  int bad = 0;
  res_t q[$];

  always #5 clk = ~clk;

  pipe_add_sub #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .sb(sb), .a(a), .b(b), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .sb_o(sb_o),
    .a_sign(a_sign), .b_sign(b_sign), .s_sign(s_sign),
    .tag_out(tag_out)
  );

  // Reference: plain modular arithmetic, carry as unsigned wrap / no-borrow.
  function automatic res_t model(logic [31:0] x, logic [31:0] y,
                                 logic s, logic [3:0] t);
    res_t r;
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint unsigned full;
    if (s) begin
      full = (ux - uy) & 64'hFFFF_FFFF;
      r.c = (ux >= uy);
    end else begin
      full = ux + uy;
      r.c = (full >= 64'h1_0000_0000);
    end
    r.sum = full[31:0];
    r.sb = s;
    r.as = x[31];
    r.bs = y[31];
    r.ss = r.sum[31];
    r.tag = t;
    return r;
  endfunction

  function automatic res_t get_out();
    return '{sum, c_out, sb_o, a_sign, b_sign, s_sign, tag_out};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0000_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Present one op with out_ready=1; report latency and the result seen.
  task automatic drive_one(input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic [3:0] t,
                           output int lat, output res_t got);
    logic acc;
    lat = 0;
    got = '0;
    in_valid = 1'b1; a = x; b = y; sb = s; tag_in = t;
    out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    acc = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (out_valid) begin
          lat = i;
          got = get_out();
          break;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h1234_5678; b = 32'h1; tag_in = 4'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (get_out() !== res_t'('0)) begin
      bad++; $display("FAIL reset_data got=%h want=0", get_out());
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat; res_t got; res_t exp;
    drive_one(32'h7FFF_FFFF, 32'h1, 1'b0, 4'h3, lat, got);
    exp = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3};
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL add_latency got=%0d want=2", lat);
    end
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL add_ovf got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_sub();
    int lat; res_t got; res_t exp;
    drive_one(32'd5, 32'd7, 1'b1, 4'h6, lat, got);
    exp = '{32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h6};
    total++;
    if (lat !== 2 || got !== exp) begin
      bad++; $display("FAIL sub_5_7 got=%h lat=%0d want=%h", got, lat, exp);
    end
    drive_one(32'd7, 32'd5, 1'b1, 4'h7, lat, got);
    exp = '{32'h0000_0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7};
    total++;
    if (lat !== 2 || got !== exp) begin
      bad++; $display("FAIL sub_7_5 got=%h lat=%0d want=%h", got, lat, exp);
    end
  endtask

  task automatic test_carry();
    int lat; res_t got; res_t exp;
    drive_one(32'h0000_FFFF, 32'h1, 1'b0, 4'h8, lat, got);
    exp = '{32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8};
    total++;
    if (lat !== 2 || got !== exp) begin
      bad++; $display("FAIL mid_carry got=%h lat=%0d want=%h", got, lat, exp);
    end
    drive_one(32'hFFFF_FFFF, 32'h1, 1'b0, 4'h9, lat, got);
    exp = '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h9};
    total++;
    if (lat !== 2 || got !== exp) begin
      bad++; $display("FAIL wrap_carry got=%h lat=%0d want=%h", got, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int got_n = 0;
    logic [31:0] xa[4];
    logic [31:0] xb[4];
    logic        xs[4];
    for (int i = 0; i < 4; i++) begin
      xa[i] = $urandom; xb[i] = $urandom; xs[i] = 1'($urandom);
    end
    q.delete();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        a = xa[idx]; b = xb[idx]; sb = xs[idx]; tag_in = 4'(idx + 1);
      end
      @(negedge clk);
      if (cyc >= 2) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
        end
        total++;
        if (!out_valid || q.size() == 0 || get_out() !== q[0]) begin
          bad++; $display("FAIL bp_hold cyc=%0d got=%h v=%b", cyc, get_out(), out_valid);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, sb, 4'(idx + 1)));
        idx++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (idx !== 2) begin
      bad++; $display("FAIL bp_accepts got=%0d want=2", idx);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got_n < 4; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        a = xa[idx]; b = xb[idx]; sb = xs[idx]; tag_in = 4'(idx + 1);
      end
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (q.size() == 0 || get_out() !== q[0] || tag_out !== 4'(got_n + 1)) begin
          bad++; $display("FAIL bp_order n=%0d got=%h", got_n, get_out());
        end
        if (q.size() != 0) void'(q.pop_front());
        got_n++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, sb, 4'(idx + 1)));
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (got_n !== 4 || q.size() != 0) begin
      bad++; $display("FAIL bp_count got=%0d want=4 left=%0d", got_n, q.size());
    end
  endtask

  task automatic test_flush();
    int lat; res_t got; res_t exp;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'd10; b = 32'd20; sb = 1'b0; tag_in = 4'hA;
    @(posedge clk); #1;
    tag_in = 4'hB;
    @(posedge clk); #1;
    out_ready = 1'b0; flush = 1'b1; tag_in = 4'hC;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL flush_setup in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL flush_clear cyc=%0d got=%b want=0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    drive_one(32'h8000_0000, 32'h8000_0000, 1'b0, 4'hD, lat, got);
    exp = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hD};
    total++;
    if (lat !== 2 || got !== exp) begin
      bad++; $display("FAIL flush_after got=%h lat=%0d want=%h", got, lat, exp);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h8000_0001; b = 32'h8000_0003; sb = 1'b1; tag_in = 4'h9;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || get_out() !== res_t'('0)) begin
      bad++; $display("FAIL rst_mid got=%h v=%b want=0", get_out(), out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_nothing_acc got=%b want=0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int acc_n = 0;
    int cyc = 0;
    q.delete();
    while ((acc_n < 10000 || q.size() != 0) && cyc < 60000) begin
      in_valid = (acc_n < 10000) && ($urandom_range(0, 3) != 0);
      a = rnd_val(); b = rnd_val(); sb = 1'($urandom); tag_in = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_spurious got=%h", get_out());
        end else if (get_out() !== q[0]) begin
          bad++; $display("FAIL rnd_data got=%h want=%h", get_out(), q[0]);
        end
        if (out_ready && q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, sb, tag_in));
        acc_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (acc_n != 10000 || q.size() != 0) begin
      bad++; $display("FAIL rnd_timeout acc=%0d left=%0d", acc_n, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
